// File: rtl/bit_serial_subtractor.sv
// rtl/bit_serial_subtractor.sv - LSB-first bit-serial unsigned subtractor with start/done handshake
//
// Computes (data_a - data_b) mod 2^NOF_BITS one bit per clock and reports the
// final borrow (data_a < data_b).
//
// Ports:
//   clk         clock, all state on posedge
//   rst_n       asynchronous active-low reset
//   start       request, sampled only while idle
//   data_a      minuend, captured on the accepting edge
//   data_b      subtrahend, captured on the accepting edge
//   data_out    registered difference, held until the next result
//   borrow_out  registered final borrow, updated with data_out
//   busy        high while an operation is in flight
//   done        one-cycle pulse when data_out/borrow_out are newly valid
module bit_serial_subtractor #(
    parameter int NOF_BITS = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic [NOF_BITS-1:0] data_a,
    input  logic [NOF_BITS-1:0] data_b,
    output logic [NOF_BITS-1:0] data_out,
    output logic                borrow_out,
    output logic                busy,
    output logic                done
);

    localparam int CW = $clog2(NOF_BITS);
    localparam logic [CW-1:0] LAST_BIT = CW'(NOF_BITS - 1);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t state;
    state_t next_state;

    logic [NOF_BITS-1:0] sa;
    logic [NOF_BITS-1:0] sb;
    // Holds the NOF_BITS-1 result bits produced so far; the bit produced on the
    // completing edge goes straight to data_out, so no extra flop is needed.
    logic [NOF_BITS-2:0] sr;
    logic                bor;
    logic [CW-1:0]       cnt;

    logic                a0;
    logic                b0;
    logic                d;
    logic                bor_next;
    logic                last;
    logic [NOF_BITS-1:0] sr_next;

    always_comb begin
        a0         = sa[0];
        b0         = sb[0];
        d          = a0 ^ b0 ^ bor;
        bor_next   = (~a0 & b0) | (~(a0 ^ b0) & bor);
        sr_next    = {d, sr};
        last       = (cnt == LAST_BIT);
        next_state = state;
        case (state)
            IDLE:    if (start) next_state = RUN;
            RUN:     if (last)  next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sa         <= '0;
            sb         <= '0;
            sr         <= '0;
            bor        <= 1'b0;
            cnt        <= '0;
            data_out   <= '0;
            borrow_out <= 1'b0;
            done       <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        sa  <= data_a;
                        sb  <= data_b;
                        bor <= 1'b0;
                        cnt <= '0;
                    end
                end
                RUN: begin
                    sa  <= {1'b0, sa[NOF_BITS-1:1]};
                    sb  <= {1'b0, sb[NOF_BITS-1:1]};
                    sr  <= sr_next[NOF_BITS-1:1];
                    bor <= bor_next;
                    if (last) begin
                        data_out   <= sr_next;
                        borrow_out <= bor_next;
                        done       <= 1'b1;
                        cnt        <= '0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy = (state == RUN);

endmodule

// File: tb/tb_bit_serial_subtractor.sv
// tb/tb_bit_serial_subtractor.sv - scoreboard bench for bit_serial_subtractor
module tb_bit_serial_subtractor;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic [7:0] data_a;
    logic [7:0] data_b;
    logic [7:0] data_out;
    logic       borrow_out;
    logic       busy;
    logic       done;

    bit_serial_subtractor #(.NOF_BITS(8)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .data_a     (data_a),
        .data_b     (data_b),
        .data_out   (data_out),
        .borrow_out (borrow_out),
        .busy       (busy),
        .done       (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    int accepted = 0;
    int done_seen = 0;
    int cycle = 0;
    int done_cyc[$];
    logic [8:0] exp_q[$];
    logic [8:0] last_res = 9'd0;

    always @(posedge clk) cycle <= cycle + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, act, req);
        end
    endtask

    // Monitor: pops on every done pulse; between pulses the outputs must hold.
    always @(negedge clk) begin
        if (rst_n) begin
            if (done === 1'b1) begin
                done_seen++;
                done_cyc.push_back(cycle);
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_done actual=1 required=0");
                end else begin
                    last_res = exp_q.pop_front();
                    check("result", {borrow_out, data_out}, last_res);
                end
            end else begin
                check("hold", {borrow_out, data_out}, last_res);
            end
        end
    end

    task automatic issue(input logic [7:0] a, input logic [7:0] b, input logic [8:0] e);
        @(negedge clk);
        data_a = a;
        data_b = b;
        start  = 1'b1;
        @(posedge clk);
        exp_q.push_back(e);
        accepted++;
    endtask

    task automatic drain();
        for (int i = 0; i < 40 && exp_q.size() != 0; i++) @(negedge clk);
        check("drain_pending", exp_q.size(), 0);
        @(negedge clk);
    endtask

    initial begin
        int n;
        rst_n  = 1'b0;
        start  = 1'b0;
        data_a = 8'd0;
        data_b = 8'd0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_data", data_out, 0);
        check("reset_borrow", borrow_out, 0);
        check("reset_busy", busy, 0);
        check("reset_done", done, 0);
        @(negedge clk);
        rst_n = 1'b1;

        // 1: 100 - 37, busy for exactly 8 cycles
        issue(8'd100, 8'd37, {1'b0, 8'd63});
        @(negedge clk);
        start = 1'b0;
        n = 0;
        for (int i = 0; i < 20; i++) begin
            if (busy) n++;
            else break;
            @(negedge clk);
        end
        check("busy_cycles", n, 8);
        drain();

        // 2: borrow cases and equal operands
        issue(8'd5, 8'd9, {1'b1, 8'd252});
        @(negedge clk); start = 1'b0;
        drain();
        issue(8'd0, 8'd1, {1'b1, 8'd255});
        @(negedge clk); start = 1'b0;
        drain();
        issue(8'd255, 8'd255, {1'b0, 8'd0});
        @(negedge clk); start = 1'b0;
        drain();

        // 3: start pulse while busy is ignored
        issue(8'd200, 8'd50, {1'b0, 8'd150});
        @(negedge clk); start = 1'b0;
        @(negedge clk);
        data_a = 8'd1; data_b = 8'd2; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        drain();

        // 4: back-to-back with start held high
        done_cyc.delete();
        issue(8'd10, 8'd3, {1'b0, 8'd7});
        @(negedge clk);
        data_a = 8'd3; data_b = 8'd10;
        repeat (9) @(posedge clk);
        exp_q.push_back({1'b1, 8'd249});
        accepted++;
        @(negedge clk); start = 1'b0;
        drain();
        check("b2b_done_count", done_cyc.size(), 2);
        if (done_cyc.size() == 2) check("b2b_spacing", done_cyc[1] - done_cyc[0], 9);

        // 5: reset in the middle of RUN aborts the operation
        issue(8'd123, 8'd45, {1'b0, 8'd78});
        @(negedge clk); start = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        rst_n = 1'b0;
        exp_q.delete();
        accepted--;
        last_res = 9'd0;
        #1;
        check("abort_data", data_out, 0);
        check("abort_borrow", borrow_out, 0);
        check("abort_busy", busy, 0);
        check("abort_done", done, 0);
        @(negedge clk);
        rst_n = 1'b1;
        issue(8'd77, 8'd7, {1'b0, 8'd70});
        @(negedge clk); start = 1'b0;
        drain();

        // 6: random pairs back-to-back, operands and start scrambled while busy
        for (int k = 0; k < 1000; k++) begin
            logic [7:0] a;
            logic [7:0] b;
            a = 8'($urandom);
            b = 8'($urandom);
            issue(a, b, {1'b0, a} - {1'b0, b});
            for (int j = 0; j < 8; j++) begin
                @(negedge clk);
                data_a = 8'($urandom);
                data_b = 8'($urandom);
                start  = 1'($urandom);
                @(posedge clk);
            end
        end
        @(negedge clk); start = 1'b0;
        drain();
        check("done_count", done_seen, accepted);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout actual=timeout required=finish");
        $fatal(1, "timeout");
    end

endmodule
